// File: rtl/draw_pkg.sv
// ============================================================================
// Module   : draw_pkg
// Summary  : Shared encodings and defaults for the framebuffer write-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package draw_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_grant   = 2'd1;
    localparam logic [1:0] c_st_busy    = 2'd2;
    localparam logic [1:0] c_st_release = 2'd3;

    localparam int c_xw_default = 10;
    localparam int c_cw_default = 3;

    localparam int c_req_pic    = 0;
    localparam int c_req_ball   = 1;
    localparam int c_req_paddle = 2;
    localparam int c_req_brick  = 3;

endpackage

`default_nettype wire

// File: rtl/draw_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Summary  : Combinational round-robin search for the first set request,
//            starting one past the pointer and wrapping at NREQ-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [PW-1:0]   o_winner,
    output logic            o_valid
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = i_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            if (!o_valid && i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/draw_arbiter.sv
// ============================================================================
// Module   : draw_arbiter
// Summary  : Hands the single VGA framebuffer write port to one draw engine at
//            a time, round-robin, starting each grant on a frame tick.
//            Optional macro DRAW_ALIGN_EN delays requester 0's x/y/plot.
// Revision : 1.0
// ============================================================================
`default_nettype none

module draw_arbiter
    import draw_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int XW        = c_xw_default,
    parameter int CW        = c_cw_default,
    parameter int ALIGN_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    busy,
    input  logic [NREQ*XW-1:0] x_in,
    input  logic [NREQ*XW-1:0] y_in,
    input  logic [NREQ*CW-1:0] colour_in,
    output logic [NREQ-1:0]    go,
    output logic [NREQ-1:0]    gnt,
    output logic [XW-1:0]      vga_x,
    output logic [XW-1:0]      vga_y,
    output logic [CW-1:0]      vga_colour,
    output logic               vga_plot
);

    localparam int c_pw    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_cnt_w = $clog2(ALIGN_LAT + 2);
`ifdef DRAW_ALIGN_EN
    localparam logic [c_cnt_w-1:0] c_rel_last = c_cnt_w'(ALIGN_LAT);
`else
    localparam logic [c_cnt_w-1:0] c_rel_last = '0;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_pw-1:0]    r_ptr;
    logic [c_pw-1:0]    r_win;
    logic [NREQ-1:0]    r_gnt;
    logic               r_seen_busy;
    logic [c_cnt_w-1:0] r_rel_cnt;
    logic               w_capture;

    logic [c_pw-1:0]    w_pick_win;
    logic               w_pick_valid;
    logic [NREQ-1:0]    w_pick_onehot;

    logic [XW-1:0]      w_x_arr [NREQ];
    logic [XW-1:0]      w_y_arr [NREQ];
    logic [CW-1:0]      w_c_arr [NREQ];

    logic [XW-1:0]      w_nxt_x;
    logic [XW-1:0]      w_nxt_y;
    logic               w_nxt_plot;
    logic               w_load_xy;
    logic               w_load_col;

    logic [XW-1:0]      r_vga_x;
    logic [XW-1:0]      r_vga_y;
    logic [CW-1:0]      r_vga_colour;
    logic               r_vga_plot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_x_arr[gi] = x_in[gi*XW +: XW];
            assign w_y_arr[gi] = y_in[gi*XW +: XW];
            assign w_c_arr[gi] = colour_in[gi*CW +: CW];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .PW   (c_pw)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_pick_win),
        .o_valid  (w_pick_valid)
    );

    assign w_pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Busy takes priority over a dropped request in GRANT: the engine has
    // already started drawing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (frame && w_pick_valid) w_state_nxt = c_st_grant;
            end
            c_st_grant: begin
                if (busy[r_win])      w_state_nxt = c_st_busy;
                else if (!req[r_win]) w_state_nxt = c_st_idle;
            end
            c_st_busy: begin
                if (r_seen_busy && !busy[r_win]) w_state_nxt = c_st_release;
            end
            c_st_release: begin
                if (r_rel_cnt == c_rel_last) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        go        = (r_state == c_st_grant) ? r_gnt : '0;
        w_capture = (r_state == c_st_grant) || (r_state == c_st_busy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= c_pw'(NREQ - 1);
            r_win       <= '0;
            r_gnt       <= '0;
            r_seen_busy <= 1'b0;
            r_rel_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_state_nxt == c_st_grant) begin
                        r_win       <= w_pick_win;
                        r_gnt       <= w_pick_onehot;
                        r_seen_busy <= 1'b0;
                    end
                end
                c_st_grant: begin
                    if (w_state_nxt == c_st_busy)      r_seen_busy <= 1'b1;
                    else if (w_state_nxt == c_st_idle) r_gnt       <= '0;
                end
                c_st_busy: begin
                    if (w_state_nxt == c_st_release) begin
                        r_ptr     <= r_win;
                        r_gnt     <= '0;
                        r_rel_cnt <= '0;
                    end
                end
                c_st_release: r_rel_cnt <= r_rel_cnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef DRAW_ALIGN_EN
    logic [ALIGN_LAT-1:0][XW-1:0] r_pipe_x;
    logic [ALIGN_LAT-1:0][XW-1:0] r_pipe_y;
    logic [ALIGN_LAT-1:0]         r_pipe_plot;
    logic                         w_pic_win;

    assign w_pic_win = (r_win == c_pw'(c_req_pic));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_x    <= '0;
            r_pipe_y    <= '0;
            r_pipe_plot <= '0;
        end else begin
            r_pipe_x[0]    <= w_x_arr[c_req_pic];
            r_pipe_y[0]    <= w_y_arr[c_req_pic];
            r_pipe_plot[0] <= w_capture && w_pic_win && busy[c_req_pic];
            for (int i = 1; i < ALIGN_LAT; i++) begin
                r_pipe_x[i]    <= r_pipe_x[i-1];
                r_pipe_y[i]    <= r_pipe_y[i-1];
                r_pipe_plot[i] <= r_pipe_plot[i-1];
            end
        end
    end
`endif

    // The blitter's pipeline keeps feeding the output through RELEASE so it
    // drains before the port is handed on.
    always_comb begin
        w_load_xy  = w_capture;
        w_load_col = w_capture;
        w_nxt_x    = w_x_arr[r_win];
        w_nxt_y    = w_y_arr[r_win];
        w_nxt_plot = w_capture && busy[r_win];
`ifdef DRAW_ALIGN_EN
        if (w_pic_win && (r_state != c_st_idle)) begin
            w_load_xy  = 1'b1;
            w_nxt_x    = r_pipe_x[ALIGN_LAT-1];
            w_nxt_y    = r_pipe_y[ALIGN_LAT-1];
            w_nxt_plot = r_pipe_plot[ALIGN_LAT-1];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_plot <= w_nxt_plot;
            if (w_load_xy) begin
                r_vga_x <= w_nxt_x;
                r_vga_y <= w_nxt_y;
            end
            if (w_load_col) r_vga_colour <= w_c_arr[r_win];
        end
    end

    assign gnt        = r_gnt;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule

`default_nettype wire

// File: tb/tb_draw_arbiter.sv
// ============================================================================
// Module   : tb_draw_arbiter
// Summary  : Self-checking bench for draw_arbiter with a transaction-level
//            model of round-robin grants and the forwarded pixel stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_draw_arbiter;

    localparam int NREQ      = 4;
    localparam int XW        = 10;
    localparam int CW        = 3;
    localparam int ALIGN_LAT = 2;
`ifdef DRAW_ALIGN_EN
    localparam int c_pic_lag = ALIGN_LAT + 1;
    localparam int c_rel_len = ALIGN_LAT + 1;
`else
    localparam int c_pic_lag = 1;
    localparam int c_rel_len = 1;
`endif
    localparam int c_hist = 4096;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    busy;
    logic [NREQ*XW-1:0] x_in;
    logic [NREQ*XW-1:0] y_in;
    logic [NREQ*CW-1:0] colour_in;
    logic [NREQ-1:0]    go;
    logic [NREQ-1:0]    gnt;
    logic [XW-1:0]      vga_x;
    logic [XW-1:0]      vga_y;
    logic [CW-1:0]      vga_colour;
    logic               vga_plot;

    always #5 clk = ~clk;

    draw_arbiter #(
        .NREQ      (NREQ),
        .XW        (XW),
        .CW        (CW),
        .ALIGN_LAT (ALIGN_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame      (frame),
        .req        (req),
        .busy       (busy),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .go         (go),
        .gnt        (gnt),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    int n_pass    = 0;
    int n_total   = 0;
    int edges     = 0;
    int rst_mark  = 0;
    int model_ptr = NREQ - 1;
    int cur_lag   = 1;

    // Pixel the granted engine presented in each cycle, indexed by cycle.
    bit            pix_v [c_hist];
    logic [XW-1:0] pix_x [c_hist];
    logic [XW-1:0] pix_y [c_hist];
    logic [CW-1:0] pix_c [c_hist];
    bit            drv_v;
    logic [XW-1:0] drv_x;
    logic [XW-1:0] drv_y;
    logic [CW-1:0] drv_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic check_stream();
        int  s;
        int  sc;
        bit  exp_plot;
        s  = edges - cur_lag;
        sc = edges - 1;
        exp_plot = (s >= rst_mark) && (s >= 0) && pix_v[s];
        chk("stream_plot", 32'(vga_plot), 32'(exp_plot));
        if (exp_plot) begin
            chk("stream_x", 32'(vga_x), 32'(pix_x[s]));
            chk("stream_y", 32'(vga_y), 32'(pix_y[s]));
        end
        if ((sc >= rst_mark) && (sc >= 0) && pix_v[sc])
            chk("stream_colour", 32'(vga_colour), 32'(pix_c[sc]));
    endtask

    task automatic tick();
        if (edges < c_hist) begin
            pix_v[edges] = drv_v;
            pix_x[edges] = drv_x;
            pix_y[edges] = drv_y;
            pix_c[edges] = drv_c;
        end
        @(posedge clk);
        #1;
        edges++;
        if (reset) rst_mark = edges;
        else       check_stream();
    endtask

    task automatic rand_data();
        logic [63:0] t;
        logic [31:0] c;
        t = {$urandom, $urandom};
        x_in = t[NREQ*XW-1:0];
        t = {$urandom, $urandom};
        y_in = t[NREQ*XW-1:0];
        c = $urandom;
        colour_in = c[NREQ*CW-1:0];
    endtask

    function automatic logic [NREQ-1:0] rnd_req();
        logic [31:0] r;
        r = $urandom;
        return r[NREQ-1:0];
    endfunction

    task automatic session(input logic [NREQ-1:0] rq, input int dly, input int npix,
                           input bit abort, input bit xframe, input bit stepx);
        int w;
        logic [NREQ-1:0] one;
        w = pick(model_ptr, rq);
        rand_data();
        req = rq;
        frame = 1'b1;
        if (w < 0) begin
            busy = rnd_req();
            tick();
            frame = 1'b0;
            chk("nogrant_gnt", 32'(gnt), 32'(0));
            chk("nogrant_go", 32'(go), 32'(0));
            busy = '0;
            return;
        end
        one = {{(NREQ-1){1'b0}}, 1'b1} << w;
        cur_lag = (w == 0) ? c_pic_lag : 1;
        busy = rnd_req() & ~one;
        tick();
        frame = 1'b0;
        chk("grant_gnt", 32'(gnt), 32'(one));
        chk("grant_go", 32'(go), 32'(one));
        for (int i = 0; i < dly; i++) begin
            rand_data();
            req   = rnd_req() | one;
            busy  = rnd_req() & ~one;
            frame = xframe && (i == 0);
            tick();
            chk("wait_gnt", 32'(gnt), 32'(one));
            chk("wait_go", 32'(go), 32'(one));
        end
        frame = 1'b0;
        if (abort) begin
            req  = rnd_req() & ~one;
            busy = rnd_req() & ~one;
            tick();
            chk("abort_gnt", 32'(gnt), 32'(0));
            chk("abort_go", 32'(go), 32'(0));
            req  = '0;
            busy = '0;
            return;
        end
        for (int k = 0; k < npix; k++) begin
            rand_data();
            if (stepx) x_in[w*XW +: XW] = XW'(k);
            req   = (k == 0) ? (rnd_req() | one) : rnd_req();
            busy  = rnd_req() | one;
            drv_v = 1'b1;
            drv_x = x_in[w*XW +: XW];
            drv_y = y_in[w*XW +: XW];
            drv_c = colour_in[w*CW +: CW];
            tick();
            chk("busy_go", 32'(go), 32'(0));
            chk("busy_gnt", 32'(gnt), 32'(one));
        end
        drv_v = 1'b0;
        rand_data();
        req  = rnd_req();
        busy = rnd_req() & ~one;
        tick();
        chk("release_gnt", 32'(gnt), 32'(0));
        chk("release_go", 32'(go), 32'(0));
        model_ptr = w;
        // Frame ticks during the guard cycles must not start a grant.
        for (int r = 0; r < c_rel_len; r++) begin
            frame = 1'b1;
            req   = '1;
            tick();
            chk("release_hold_gnt", 32'(gnt), 32'(0));
        end
        frame = 1'b0;
        req   = '0;
        busy  = '0;
    endtask

    initial begin
        reset = 1'b1;
        frame = 1'b0;
        req   = '0;
        busy  = '0;
        x_in  = '0;
        y_in  = '0;
        colour_in = '0;
        drv_v = 1'b0;
        drv_x = '0;
        drv_y = '0;
        drv_c = '0;
        tick();
        tick();
        chk("reset_gnt", 32'(gnt), 32'(0));
        chk("reset_go", 32'(go), 32'(0));
        chk("reset_plot", 32'(vga_plot), 32'(0));
        chk("reset_x", 32'(vga_x), 32'(0));
        chk("reset_y", 32'(vga_y), 32'(0));
        chk("reset_colour", 32'(vga_colour), 32'(0));
        reset = 1'b0;

        // Reset in the middle of a blit aborts the grant.
        req = 4'b0001;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("midrst_grant", 32'(gnt), 32'(1));
        cur_lag = c_pic_lag;
        for (int k = 0; k < 2; k++) begin
            rand_data();
            busy  = 4'b0001;
            drv_v = 1'b1;
            drv_x = x_in[XW-1:0];
            drv_y = y_in[XW-1:0];
            drv_c = colour_in[CW-1:0];
            tick();
        end
        drv_v = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_gnt", 32'(gnt), 32'(0));
        chk("midrst_go", 32'(go), 32'(0));
        chk("midrst_plot", 32'(vga_plot), 32'(0));
        chk("midrst_x", 32'(vga_x), 32'(0));
        reset = 1'b0;
        busy  = '0;
        req   = '0;
        model_ptr = NREQ - 1;

        // Full contention: order 0,1,2,3,0 starting from the reset pointer.
        for (int f = 0; f < 5; f++) session(4'b1111, f % 3, 4, 1'b0, 1'b0, 1'b0);

        session(4'b0001, 2, 3, 1'b0, 1'b0, 1'b1);
        session(4'b0100, 1, 0, 1'b1, 1'b0, 1'b0);
        session(4'b0110, 0, 2, 1'b0, 1'b0, 1'b0);
        session(4'b0001, 3, 2, 1'b0, 1'b1, 1'b0);
        session(4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            session(rnd_req(), $urandom_range(0, 3), $urandom_range(1, 6),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
